// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: buffers {j,k} commands with repeat counts in a small FIFO
// and replays each one as registered J/K pairs for a downstream JK flop.
// It also tracks a cycle-accurate model of that flop's q output.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready push handshake; cmd_ready = (count != DEPTH)
//   cmd_op[1:0]         {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
//   cmd_rep[REP_W-1:0]  extra presentations (op shown cmd_rep+1 times)
//   en                  issue enable; 0 pauses presentation (shows 00)
//   j, k                registered J/K to the downstream flop
//   q_model             expected downstream q
//   busy                work pending (rem != 0 or FIFO non-empty)
//   count[CW-1:0]       commands held in the FIFO
module jk_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REP_W = 3,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [REP_W-1:0] cmd_rep,
  input  logic             en,
  output logic             j,
  output logic             k,
  output logic             q_model,
  output logic             busy,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [1:0]       op;
    logic [REP_W-1:0] rep;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } seq_state_e;

  cmd_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic [1:0]       cur_op_q, cur_op_d;
  logic [1:0]       jk_q, jk_d;
  logic             q_model_q, q_model_d;

  seq_state_e       state_c;
  cmd_t             head_c;
  logic             push_c;
  logic             pop_c;
  logic             pending_c;

  // Handshake and status derive from registered state only.
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign pending_c = (rem_q != '0) || (count_q != '0);
  assign busy      = pending_c;
  assign count     = count_q;
  assign j         = jk_q[1];
  assign k         = jk_q[0];
  assign q_model   = q_model_q;
  assign push_c    = cmd_valid && cmd_ready;
  assign head_c    = mem_q[rd_ptr_q];

  // Sequencer phase, derived from pending work and the enable.
  always_comb begin
    state_c = ST_IDLE;
    if (pending_c) begin
      state_c = en ? ST_RUN : ST_PAUSE;
    end
  end

  // Presentation: finish the current command before popping the next one.
  always_comb begin
    jk_d     = 2'b00;
    rem_d    = rem_q;
    cur_op_d = cur_op_q;
    pop_c    = 1'b0;
    case (state_c)
      ST_RUN: begin
        if (rem_q != '0) begin
          jk_d  = cur_op_q;
          rem_d = REP_W'(rem_q - 1'b1);
        end else begin
          // rem is zero and work is pending, so the FIFO is non-empty.
          pop_c    = 1'b1;
          cur_op_d = head_c.op;
          jk_d     = head_c.op;
          rem_d    = head_c.rep;
        end
      end
      default: jk_d = 2'b00;
    endcase
  end

  // FIFO bookkeeping; no bypass, so a fresh push is popped one edge later.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = '{op: cmd_op, rep: cmd_rep};
      wr_ptr_d        = PW'(wr_ptr_q + 1'b1);
    end
    if (pop_c) begin
      rd_ptr_d = PW'(rd_ptr_q + 1'b1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = CW'(count_q + 1'b1);
      2'b01:   count_d = CW'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
  end

  // Downstream flop model, driven by the pre-edge j,k like the real flop.
  always_comb begin
    q_model_d = q_model_q;
    case (jk_q)
      2'b10:   q_model_d = 1'b1;
      2'b01:   q_model_d = 1'b0;
      2'b11:   q_model_d = ~q_model_q;
      default: q_model_d = q_model_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      cur_op_q  <= 2'b00;
      jk_q      <= 2'b00;
      q_model_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      cur_op_q  <= cur_op_d;
      jk_q      <= jk_d;
      q_model_q <= q_model_d;
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: a per-edge vector table followed by
// a hand-written asynchronous-reset-mid-run sequence.
module tb_jk_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_rep;
  logic       en;
  logic       j;
  logic       k;
  logic       q_model;
  logic       busy;
  logic [2:0] count;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [2:0] rep;
    logic       en;
    logic [1:0] jk;
    logic       q;
    logic       rdy;
    logic       busy;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  jk_cmd_sequencer #(.DEPTH(4), .REP_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rep   (cmd_rep),
    .en        (en),
    .j         (j),
    .k         (k),
    .q_model   (q_model),
    .busy      (busy),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic v, input logic [1:0] op, input logic [2:0] rep,
                     input logic e, input logic [1:0] xjk, input logic xq,
                     input logic xrdy, input logic xbusy, input logic [2:0] xcnt);
    vec_t t;
    t.v = v; t.op = op; t.rep = rep; t.en = e;
    t.jk = xjk; t.q = xq; t.rdy = xrdy; t.busy = xbusy; t.cnt = xcnt;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] xjk,
                       input logic xq, input logic xrdy, input logic xbusy,
                       input logic [2:0] xcnt);
    n_tests++;
    if ({j, k} !== xjk || q_model !== xq || cmd_ready !== xrdy ||
        busy !== xbusy || count !== xcnt) begin
      n_fail++;
      $display("FAIL %s[%0d]: got jk=%b q=%b rdy=%b busy=%b cnt=%0d, want jk=%b q=%b rdy=%b busy=%b cnt=%0d",
               name, idx, {j, k}, q_model, cmd_ready, busy, count,
               xjk, xq, xrdy, xbusy, xcnt);
    end
  endtask

  // Drive inputs, take one edge, then sample 1 time unit after it.
  task automatic apply(input string name, input int idx, input vec_t t);
    cmd_valid = t.v;
    cmd_op    = t.op;
    cmd_rep   = t.rep;
    en        = t.en;
    @(posedge clk);
    #1;
    check(name, idx, t.jk, t.q, t.rdy, t.busy, t.cnt);
  endtask

  initial begin
    vec_t t;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_rep   = 3'd0;
    en        = 1'b0;

    //  v  op     rep   en    jk     q     rdy   busy  cnt
    // Single set: accepted at edge 1, shown after edge 2 only.
    add(1, 2'b10, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 3'd1);
    add(0, 2'b00, 3'd0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0);
    // Toggle rep=3 from q=1: four 11 cycles, q 0,1,0,1.
    add(1, 2'b11, 3'd3, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 3'd1);
    add(0, 2'b00, 3'd0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0);
    // Fill with en=0; fifth command held until the first pop.
    add(1, 2'b10, 3'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 3'd1);
    add(1, 2'b01, 3'd1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 3'd2);
    add(1, 2'b11, 3'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 3'd3);
    add(1, 2'b00, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'd4);
    add(1, 2'b10, 3'd2, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 3'd4);
    // Drain: 10,01,01,11,00,10,10,10 with no gaps.
    add(1, 2'b10, 3'd2, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 3'd3);
    add(1, 2'b10, 3'd2, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 3'd3);
    add(0, 2'b00, 3'd0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 3'd3);
    add(0, 2'b00, 3'd0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 3'd2);
    add(0, 2'b00, 3'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 3'd1);
    add(0, 2'b00, 3'd0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0);
    // Pause mid-command: 11,11,00,00,00,11 and three toggles.
    add(1, 2'b11, 3'd2, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 3'd1);
    add(0, 2'b00, 3'd0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 3'd0);
    add(0, 2'b00, 3'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 3'd0);
    add(0, 2'b00, 3'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 3'd0);
    add(0, 2'b00, 3'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0);
    // Full with pop then push, write pointer wrapping to slot 0.
    add(1, 2'b01, 3'd1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 3'd1);
    add(1, 2'b10, 3'd1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 3'd2);
    add(1, 2'b11, 3'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 3'd3);
    add(1, 2'b01, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'd4);
    add(1, 2'b10, 3'd0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 3'd3);
    add(1, 2'b10, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 3'd4);
    add(0, 2'b00, 3'd0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 3'd3);
    add(0, 2'b00, 3'd0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 3'd3);
    add(0, 2'b00, 3'd0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 3'd2);
    add(0, 2'b00, 3'd0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 3'd1);
    add(0, 2'b00, 3'd0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0);
    add(0, 2'b00, 3'd0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 3'd0);

    // Reset state.
    #12;
    check("reset", 0, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply("vec", i, vecs[i]);

    // Reset mid-run: toggle rep=5 in flight with three commands queued.
    t = '{v: 1, op: 2'b11, rep: 3'd5, en: 1, jk: 2'b00, q: 1, rdy: 1, busy: 1, cnt: 3'd1};
    apply("midrst", 0, t);
    t = '{v: 1, op: 2'b10, rep: 3'd0, en: 1, jk: 2'b11, q: 1, rdy: 1, busy: 1, cnt: 3'd1};
    apply("midrst", 1, t);
    t = '{v: 1, op: 2'b01, rep: 3'd0, en: 1, jk: 2'b11, q: 0, rdy: 1, busy: 1, cnt: 3'd2};
    apply("midrst", 2, t);
    t = '{v: 1, op: 2'b00, rep: 3'd0, en: 1, jk: 2'b11, q: 1, rdy: 1, busy: 1, cnt: 3'd3};
    apply("midrst", 3, t);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async", 0, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0);
    cmd_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    // Nothing from before the reset may be replayed.
    for (int i = 0; i < 4; i++) begin
      t = '{v: 0, op: 2'b00, rep: 3'd0, en: 1, jk: 2'b00, q: 0, rdy: 1, busy: 0, cnt: 3'd0};
      apply("post_rst", i, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
